// File: rtl/branch_resolve_pipe.sv
// branch_resolve_pipe
// Carries per-fetch prediction metadata ID -> EX -> MEM, merges it with the
// branch outcome resolved in EX, and presents the registered EXMEM_* update /
// recovery packet for the agree predictor. Detects mispredictions, squashes
// wrong-path slots, and keeps saturating branch / mispredict statistics.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   IF_*                    fetch PC and predictor outputs for this fetch
//   stall_i                 hold ID, insert a bubble into EX
//   flush_i                 external squash, same effect as a mispredict
//   EX_*                    decoded class, comparator result, resolved target
//   EXMEM_*                 registered commit-stage update/recovery packet
//   mispredict_o            commit-stage redirect required (from MEM regs)
//   branch_cnt_o,
//   mispredict_cnt_o        saturating statistics, cleared by cnt_clr_i
module branch_resolve_pipe #(
  parameter int unsigned INDEX_WIDTH   = 6,
  parameter int unsigned HISTORY_WIDTH = 8,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        IF_valid_i,
  input  logic [31:0]                 IF_pc_i,
  input  logic                        IF_btb_hit_i,
  input  logic                        IF_prediction_i,
  input  logic                        IF_bias_i,
  input  logic [HISTORY_WIDTH-1:0]    IF_ghr_data_i,
  input  logic                        stall_i,
  input  logic                        flush_i,
  input  logic                        EX_is_branch_i,
  input  logic                        EX_is_jal_i,
  input  logic                        EX_is_jalr_i,
  input  logic                        EX_br_taken_i,
  input  logic [31:0]                 EX_target_i,
  output logic [INDEX_WIDTH-1:0]      EXMEM_btb_wr_index_o,
  output logic [31-INDEX_WIDTH-2:0]   EXMEM_btb_wr_tag_o,
  output logic [31:0]                 EXMEM_btb_wr_target_o,
  output logic [HISTORY_WIDTH-1:0]    EXMEM_pht_wr_index_o,
  output logic                        EXMEM_btb_hit_o,
  output logic                        EXMEM_prediction_o,
  output logic                        EXMEM_bias_o,
  output logic [HISTORY_WIDTH-1:0]    EXMEM_ghr_data_o,
  output logic                        EXMEM_is_jmp_o,
  output logic                        EXMEM_br_decision_o,
  output logic [31:0]                 EXMEM_pcplus4_o,
  output logic                        mispredict_o,
  output logic [CNT_WIDTH-1:0]        branch_cnt_o,
  output logic [CNT_WIDTH-1:0]        mispredict_cnt_o,
  input  logic                        cnt_clr_i
);

  localparam int unsigned TW = 32 - INDEX_WIDTH - 2;

  // ID slot
  logic                     r_id_valid;
  logic [31:0]              r_id_pc;
  logic                     r_id_hit, r_id_pred, r_id_bias;
  logic [HISTORY_WIDTH-1:0] r_id_ghr;

  // EX slot
  logic                     r_ex_valid;
  logic [31:0]              r_ex_pc;
  logic                     r_ex_hit, r_ex_pred, r_ex_bias;
  logic [HISTORY_WIDTH-1:0] r_ex_ghr;

  // MEM slot; only pc[31:2] is needed for the index/tag fields
  logic                     r_mem_valid;
  logic [29:0]              r_mem_pc_w;
  logic [31:0]              r_mem_pcplus4;
  logic                     r_mem_hit, r_mem_pred, r_mem_bias;
  logic [HISTORY_WIDTH-1:0] r_mem_ghr;
  logic                     r_mem_is_jmp, r_mem_dec;
  logic [31:0]              r_mem_target;

  logic [CNT_WIDTH-1:0]     r_branch_cnt, r_mispredict_cnt;

  // next MEM contents
  logic                     w_mem_valid;
  logic [29:0]              w_mem_pc_w;
  logic [31:0]              w_mem_pcplus4;
  logic                     w_mem_hit, w_mem_pred, w_mem_bias;
  logic [HISTORY_WIDTH-1:0] w_mem_ghr;
  logic                     w_mem_is_jmp, w_mem_dec;
  logic [31:0]              w_mem_target;

  logic w_mispredict;
  logic w_squash;
  logic w_br_inc, w_mp_inc;

  // Redirect: a jump whose prediction disagrees, or any non-jump that redirects (JALR)
  assign w_mispredict = r_mem_valid &
                        ((r_mem_is_jmp & (r_mem_pred ^ r_mem_dec)) | (~r_mem_is_jmp & r_mem_dec));
  assign w_squash     = w_mispredict | flush_i;

  // EX -> MEM merge; bubbles and squashed slots produce an all-zero packet
  always_comb begin
    w_mem_valid   = 1'b0;
    w_mem_pc_w    = '0;
    w_mem_pcplus4 = '0;
    w_mem_hit     = 1'b0;
    w_mem_pred    = 1'b0;
    w_mem_bias    = 1'b0;
    w_mem_ghr     = '0;
    w_mem_is_jmp  = 1'b0;
    w_mem_dec     = 1'b0;
    w_mem_target  = '0;
    if (r_ex_valid && !w_squash) begin
      w_mem_valid   = 1'b1;
      w_mem_pc_w    = r_ex_pc[31:2];
      w_mem_pcplus4 = r_ex_pc + 32'd4;
      w_mem_hit     = r_ex_hit;
      w_mem_pred    = r_ex_pred;
      w_mem_bias    = r_ex_bias;
      w_mem_ghr     = r_ex_ghr;
      w_mem_is_jmp  = EX_is_branch_i | EX_is_jal_i;
      w_mem_dec     = (EX_is_branch_i & EX_br_taken_i) | EX_is_jal_i | EX_is_jalr_i;
      w_mem_target  = EX_target_i;
    end
  end

  // ID / EX slots: squash beats stall; stall holds ID and bubbles EX
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_id_valid <= 1'b0;
      r_id_pc    <= '0;
      r_id_hit   <= 1'b0;
      r_id_pred  <= 1'b0;
      r_id_bias  <= 1'b0;
      r_id_ghr   <= '0;
      r_ex_valid <= 1'b0;
      r_ex_pc    <= '0;
      r_ex_hit   <= 1'b0;
      r_ex_pred  <= 1'b0;
      r_ex_bias  <= 1'b0;
      r_ex_ghr   <= '0;
    end else if (w_squash) begin
      r_id_valid <= 1'b0;
      r_ex_valid <= 1'b0;
    end else begin
      if (!stall_i) begin
        r_id_valid <= IF_valid_i;
        r_id_pc    <= IF_pc_i;
        r_id_hit   <= IF_btb_hit_i;
        r_id_pred  <= IF_prediction_i;
        r_id_bias  <= IF_bias_i;
        r_id_ghr   <= IF_ghr_data_i;
      end
      r_ex_valid <= r_id_valid & ~stall_i;
      r_ex_pc    <= r_id_pc;
      r_ex_hit   <= r_id_hit;
      r_ex_pred  <= r_id_pred;
      r_ex_bias  <= r_id_bias;
      r_ex_ghr   <= r_id_ghr;
    end
  end

  // MEM slot
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mem_valid   <= 1'b0;
      r_mem_pc_w    <= '0;
      r_mem_pcplus4 <= '0;
      r_mem_hit     <= 1'b0;
      r_mem_pred    <= 1'b0;
      r_mem_bias    <= 1'b0;
      r_mem_ghr     <= '0;
      r_mem_is_jmp  <= 1'b0;
      r_mem_dec     <= 1'b0;
      r_mem_target  <= '0;
    end else begin
      r_mem_valid   <= w_mem_valid;
      r_mem_pc_w    <= w_mem_pc_w;
      r_mem_pcplus4 <= w_mem_pcplus4;
      r_mem_hit     <= w_mem_hit;
      r_mem_pred    <= w_mem_pred;
      r_mem_bias    <= w_mem_bias;
      r_mem_ghr     <= w_mem_ghr;
      r_mem_is_jmp  <= w_mem_is_jmp;
      r_mem_dec     <= w_mem_dec;
      r_mem_target  <= w_mem_target;
    end
  end

  // Saturating statistics; clear wins over a same-cycle event
  assign w_br_inc = r_mem_valid & r_mem_is_jmp & (r_branch_cnt != {CNT_WIDTH{1'b1}});
  assign w_mp_inc = w_mispredict & (r_mispredict_cnt != {CNT_WIDTH{1'b1}});

  always_ff @(posedge clk_i) begin
    if (rst_i || cnt_clr_i) begin
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      if (w_br_inc) r_branch_cnt     <= r_branch_cnt + CNT_WIDTH'(1);
      if (w_mp_inc) r_mispredict_cnt <= r_mispredict_cnt + CNT_WIDTH'(1);
    end
  end

  assign EXMEM_btb_wr_index_o  = r_mem_pc_w[INDEX_WIDTH-1:0];
  assign EXMEM_btb_wr_tag_o    = r_mem_pc_w[29:INDEX_WIDTH];
  assign EXMEM_btb_wr_target_o = r_mem_target;
  assign EXMEM_pht_wr_index_o  = r_mem_pc_w[HISTORY_WIDTH-1:0];
  assign EXMEM_btb_hit_o       = r_mem_hit;
  assign EXMEM_prediction_o    = r_mem_pred;
  assign EXMEM_bias_o          = r_mem_bias;
  assign EXMEM_ghr_data_o      = r_mem_ghr;
  assign EXMEM_is_jmp_o        = r_mem_is_jmp;
  assign EXMEM_br_decision_o   = r_mem_dec;
  assign EXMEM_pcplus4_o       = r_mem_pcplus4;
  assign mispredict_o          = w_mispredict;
  assign branch_cnt_o          = r_branch_cnt;
  assign mispredict_cnt_o      = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_resolve_pipe.sv
// Bench for branch_resolve_pipe: directed scenarios plus randomized traffic,
// checked against a queue-based model of in-flight fetches. A second instance
// with 4-bit counters exercises saturation.
module tb_branch_resolve_pipe;
  localparam int IW  = 6;
  localparam int HW  = 8;
  localparam int TWB = 32 - IW - 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, if_valid, if_hit, if_pred, if_bias, stall, flush;
  logic ex_br, ex_jal, ex_jalr, ex_tk, cnt_clr;
  logic [31:0] if_pc, ex_tgt;
  logic [HW-1:0] if_ghr;

  logic [IW-1:0] o_idx, o_idx4;
  logic [TWB-1:0] o_tag, o_tag4;
  logic [31:0] o_tgt, o_tgt4, o_pc4, o_pc44, o_bc, o_mc;
  logic [HW-1:0] o_pht, o_pht4, o_ghr, o_ghr4;
  logic o_hit, o_pred, o_bias, o_isj, o_dec, o_mis;
  logic o_hit4, o_pred4, o_bias4, o_isj4, o_dec4, o_mis4;
  logic [3:0] o_bc4, o_mc4;

  branch_resolve_pipe dut (
    .clk_i(clk), .rst_i(rst), .IF_valid_i(if_valid), .IF_pc_i(if_pc),
    .IF_btb_hit_i(if_hit), .IF_prediction_i(if_pred), .IF_bias_i(if_bias),
    .IF_ghr_data_i(if_ghr), .stall_i(stall), .flush_i(flush),
    .EX_is_branch_i(ex_br), .EX_is_jal_i(ex_jal), .EX_is_jalr_i(ex_jalr),
    .EX_br_taken_i(ex_tk), .EX_target_i(ex_tgt),
    .EXMEM_btb_wr_index_o(o_idx), .EXMEM_btb_wr_tag_o(o_tag),
    .EXMEM_btb_wr_target_o(o_tgt), .EXMEM_pht_wr_index_o(o_pht),
    .EXMEM_btb_hit_o(o_hit), .EXMEM_prediction_o(o_pred), .EXMEM_bias_o(o_bias),
    .EXMEM_ghr_data_o(o_ghr), .EXMEM_is_jmp_o(o_isj), .EXMEM_br_decision_o(o_dec),
    .EXMEM_pcplus4_o(o_pc4), .mispredict_o(o_mis),
    .branch_cnt_o(o_bc), .mispredict_cnt_o(o_mc), .cnt_clr_i(cnt_clr));

  branch_resolve_pipe #(.CNT_WIDTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .IF_valid_i(if_valid), .IF_pc_i(if_pc),
    .IF_btb_hit_i(if_hit), .IF_prediction_i(if_pred), .IF_bias_i(if_bias),
    .IF_ghr_data_i(if_ghr), .stall_i(stall), .flush_i(flush),
    .EX_is_branch_i(ex_br), .EX_is_jal_i(ex_jal), .EX_is_jalr_i(ex_jalr),
    .EX_br_taken_i(ex_tk), .EX_target_i(ex_tgt),
    .EXMEM_btb_wr_index_o(o_idx4), .EXMEM_btb_wr_tag_o(o_tag4),
    .EXMEM_btb_wr_target_o(o_tgt4), .EXMEM_pht_wr_index_o(o_pht4),
    .EXMEM_btb_hit_o(o_hit4), .EXMEM_prediction_o(o_pred4), .EXMEM_bias_o(o_bias4),
    .EXMEM_ghr_data_o(o_ghr4), .EXMEM_is_jmp_o(o_isj4), .EXMEM_br_decision_o(o_dec4),
    .EXMEM_pcplus4_o(o_pc44), .mispredict_o(o_mis4),
    .branch_cnt_o(o_bc4), .mispredict_cnt_o(o_mc4), .cnt_clr_i(cnt_clr));

  typedef struct packed {
    logic v; logic [31:0] pc; logic hit, pred, bias; logic [HW-1:0] ghr;
  } fetch_t;
  typedef struct packed {
    logic v; logic [31:0] pc; logic hit, pred, bias; logic [HW-1:0] ghr;
    logic isj, dec; logic [31:0] tgt;
  } mem_t;

  // Model: q[0] is the older in-flight fetch (EX), q[1] the younger (ID)
  fetch_t q[$];
  mem_t   m;
  longint unsigned bc, mc, bc4, mc4;
  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic mdl_mis();
    return m.v && (m.isj ? (m.pred != m.dec) : m.dec);
  endfunction

  function automatic longint unsigned sat_inc(longint unsigned c, int w, logic ev);
    longint unsigned mx = (64'd1 << w) - 1;
    if (!ev || c == mx) return c;
    return c + 1;
  endfunction

  task automatic check_pkt(input string p,
      input logic [63:0] idx, tag, tgt, pht, hit, pred, bias, ghr, isj, dec, pc4, mis);
    chk({p, "idx"},  idx,  64'((m.pc >> 2) % (32'd1 << IW)));
    chk({p, "tag"},  tag,  64'(m.pc >> (IW + 2)));
    chk({p, "tgt"},  tgt,  64'(m.tgt));
    chk({p, "pht"},  pht,  64'((m.pc >> 2) % (32'd1 << HW)));
    chk({p, "hit"},  hit,  64'(m.hit));
    chk({p, "pred"}, pred, 64'(m.pred));
    chk({p, "bias"}, bias, 64'(m.bias));
    chk({p, "ghr"},  ghr,  64'(m.ghr));
    chk({p, "isj"},  isj,  64'(m.isj));
    chk({p, "dec"},  dec,  64'(m.dec));
    chk({p, "pc4"},  pc4,  m.v ? 64'(m.pc + 32'd4) : 64'd0);
    chk({p, "mis"},  mis,  64'(mdl_mis()));
  endtask

  task automatic check_outputs();
    check_pkt("", o_idx, o_tag, o_tgt, o_pht, o_hit, o_pred, o_bias, o_ghr,
              o_isj, o_dec, o_pc4, o_mis);
    check_pkt("w4_", o_idx4, o_tag4, o_tgt4, o_pht4, o_hit4, o_pred4, o_bias4, o_ghr4,
              o_isj4, o_dec4, o_pc44, o_mis4);
    chk("bcnt", o_bc, bc);
    chk("mcnt", o_mc, mc);
    chk("bcnt4", o_bc4, bc4);
    chk("mcnt4", o_mc4, mc4);
  endtask

  task automatic model_update();
    logic mis;
    fetch_t e, f, bub;
    mis = mdl_mis();
    bub = '0;
    if (rst || cnt_clr) begin
      bc = 0; mc = 0; bc4 = 0; mc4 = 0;
    end else begin
      bc  = sat_inc(bc,  32, m.v & m.isj);
      mc  = sat_inc(mc,  32, mis);
      bc4 = sat_inc(bc4, 4,  m.v & m.isj);
      mc4 = sat_inc(mc4, 4,  mis);
    end
    if (rst || mis || flush) begin
      q.delete(); q.push_back(bub); q.push_back(bub);
      m = '0;
    end else begin
      e = q.pop_front();
      m = '0;
      if (e.v) begin
        m.v = 1'b1; m.pc = e.pc; m.hit = e.hit; m.pred = e.pred;
        m.bias = e.bias; m.ghr = e.ghr;
        m.isj = ex_br | ex_jal;
        m.dec = (ex_br & ex_tk) | ex_jal | ex_jalr;
        m.tgt = ex_tgt;
      end
      if (stall) q.push_front(bub);
      else begin
        f.v = if_valid; f.pc = if_pc; f.hit = if_hit; f.pred = if_pred;
        f.bias = if_bias; f.ghr = if_ghr;
        q.push_back(f);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rst = 0; if_valid = 0; if_pc = 0; if_hit = 0; if_pred = 0; if_bias = 0;
    if_ghr = 0; stall = 0; flush = 0; ex_br = 0; ex_jal = 0; ex_jalr = 0;
    ex_tk = 0; ex_tgt = 0; cnt_clr = 0;
  endtask

  task automatic rand_inputs();
    int k;
    if_valid = 1'($urandom); if_pc = $urandom; if_hit = 1'($urandom);
    if_pred = 1'($urandom); if_bias = 1'($urandom); if_ghr = HW'($urandom);
    stall = ($urandom_range(0, 7) == 0); flush = ($urandom_range(0, 15) == 0);
    k = $urandom_range(0, 3);
    ex_br = (k == 1); ex_jal = (k == 2); ex_jalr = (k == 3);
    ex_tk = 1'($urandom); ex_tgt = $urandom;
    cnt_clr = ($urandom_range(0, 63) == 0);
  endtask

  task automatic set_if(input logic [31:0] pc, input logic pred);
    if_valid = 1; if_pc = pc; if_pred = pred; if_hit = 1; if_bias = pred;
    if_ghr = HW'($urandom);
  endtask

  initial begin
    bit found;
    m = '0; bc = 0; mc = 0; bc4 = 0; mc4 = 0;
    q.push_back('0); q.push_back('0);

    // reset held two cycles with random inputs
    rand_inputs(); rst = 1;
    @(posedge clk); #1;
    rand_inputs(); rst = 1;
    step();
    quiet(); step();

    // correct taken branch
    set_if(32'h104, 1); if_ghr = 8'h5A; step();
    quiet(); step();
    ex_br = 1; ex_tk = 1; ex_tgt = 32'h80; step();
    chk("t1_idx", o_idx, 64'h01); chk("t1_tag", o_tag, 64'h000001);
    chk("t1_pht", o_pht, 64'h41); chk("t1_tgt", o_tgt, 64'h80);
    chk("t1_isj", o_isj, 1); chk("t1_dec", o_dec, 1);
    chk("t1_pc4", o_pc4, 64'h108); chk("t1_mis", o_mis, 0);
    chk("t1_ghr", o_ghr, 64'h5A);
    quiet(); step();
    chk("t1_bcnt", o_bc, 1);

    // mispredict (pred=0, taken) with younger fetches behind it
    set_if(32'h200, 0); step();
    set_if(32'h204, 1); step();
    set_if(32'h208, 1); ex_br = 1; ex_tk = 1; ex_tgt = 32'h300; step();
    chk("t2_mis", o_mis, 1);
    for (int k = 0; k < 4; k++) begin
      quiet(); set_if(32'h20C + 32'(4 * k), 1); ex_jal = 1; step();
      if (k == 0) begin
        chk("t2_mis_once", o_mis, 0);
        chk("t2_mcnt", o_mc, 1);
      end
      chk("t2_bubble_pc4", o_pc4, (k == 3) ? 64'h214 : 64'h0);
    end
    quiet(); flush = 1; step();
    quiet(); step();

    // JALR, not predicted: always redirects, not counted as a branch
    set_if(32'h300, 0); step();
    quiet(); step();
    ex_jalr = 1; ex_tgt = 32'h400; step();
    chk("t3_isj", o_isj, 0); chk("t3_dec", o_dec, 1);
    chk("t3_mis", o_mis, 1); chk("t3_tgt", o_tgt, 64'h400);
    quiet(); step();
    chk("t3_bcnt", o_bc, 3); chk("t3_mcnt", o_mc, 2);

    // two stall cycles with a branch in ID
    set_if(32'h500, 1); step();
    quiet(); stall = 1; step();
    quiet(); stall = 1; step();
    quiet(); step();
    chk("t4_early", o_pc4, 0);
    ex_br = 1; ex_tk = 1; ex_tgt = 32'h600; step();
    chk("t4_pc4", o_pc4, 64'h504); chk("t4_isj", o_isj, 1);
    chk("t4_pred", o_pred, 1); chk("t4_mis", o_mis, 0);

    // stall coinciding with a mispredict: squash wins
    quiet(); step();
    set_if(32'h700, 0); step();
    set_if(32'h704, 1); step();
    set_if(32'h708, 1); ex_br = 1; ex_tk = 1; step();
    chk("t5_mis", o_mis, 1);
    quiet(); stall = 1; set_if(32'h70C, 1); ex_jal = 1; step();
    quiet(); ex_jal = 1; step();
    chk("t5_e_pc4", o_pc4, 0);
    quiet(); ex_jal = 1; step();
    chk("t5_f_pc4", o_pc4, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      rst = ($urandom_range(0, 127) == 0);
      step();
    end

    // saturation: stream of JALRs, each mispredicting
    quiet(); rst = 1; step();
    for (int i = 0; i < 70; i++) begin
      quiet(); set_if($urandom, 1'($urandom)); ex_jalr = 1; step();
    end
    chk("sat_mcnt4", o_mc4, 15);

    // clear coinciding with a mispredict event
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      quiet(); set_if($urandom, 0); ex_jalr = 1;
      if (mdl_mis()) begin
        cnt_clr = 1; found = 1;
      end
      step();
    end
    chk("clr_found", 64'(found), 1);
    chk("clr_mcnt", o_mc, 0); chk("clr_mcnt4", o_mc4, 0);
    quiet(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/branch_resolve_pipe.md
# branch_resolve_pipe

Carries each fetched instruction's prediction metadata from the predictor's IF outputs down the pipeline to the commit (MEM) stage. It merges that metadata with the branch outcome resolved in EX and presents the registered EXMEM_* update/recovery packet that the agree predictor consumes. It also detects mispredictions, squashes wrong-path metadata in flight, and keeps saturating branch and mispredict statistics.

## Interface
- INDEX_WIDTH, 6, BTB index width; tag width is TW = 32-INDEX_WIDTH-2
- HISTORY_WIDTH, 8, PHT index / GHR width
- CNT_WIDTH, 32, statistics counter width
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- IF_valid_i  in  1  IF holds a real instruction
- IF_pc_i  in  32  fetch PC
- IF_btb_hit_i, IF_prediction_i, IF_bias_i  in  1 each  predictor outputs for this fetch
- IF_ghr_data_i  in  HISTORY_WIDTH  GHR value used for this fetch
- stall_i  in  1  load-use stall: hold the ID slot, insert a bubble into EX
- flush_i  in  1  external squash (trap), same effect as a mispredict
- EX_is_branch_i, EX_is_jal_i, EX_is_jalr_i  in  1 each  decoded class of the EX instruction
- EX_br_taken_i  in  1  comparator result
- EX_target_i  in  32  computed target
- EXMEM_btb_wr_index_o  out  INDEX_WIDTH  pc[INDEX_WIDTH+1:2]
- EXMEM_btb_wr_tag_o  out  TW  pc[31:INDEX_WIDTH+2]
- EXMEM_btb_wr_target_o  out  32  resolved target
- EXMEM_pht_wr_index_o  out  HISTORY_WIDTH  pc[HISTORY_WIDTH+1:2]
- EXMEM_btb_hit_o, EXMEM_prediction_o, EXMEM_bias_o  out  1 each  carried metadata
- EXMEM_ghr_data_o  out  HISTORY_WIDTH  carried GHR
- EXMEM_is_jmp_o  out  1  B-type or JAL
- EXMEM_br_decision_o  out  1  actual redirect
- EXMEM_pcplus4_o  out  32  pc+4, recovery address
- mispredict_o  out  1  commit-stage redirect required
- branch_cnt_o, mispredict_cnt_o  out  CNT_WIDTH  statistics
- cnt_clr_i  in  1  synchronous clear of both counters

## Operation
- Three slots, each holding a valid bit plus metadata: ID, EX and MEM. The MEM slot drives all EXMEM_* outputs directly from registers.
- Each cycle:
  - ID <= IF inputs, with valid = IF_valid_i.
  - EX <= ID.
  - MEM <= EX, merged with the EX_* inputs.
- Merge rules at the EX->MEM capture, with a valid EX slot:
  - is_jmp = is_branch | is_jal.
  - br_decision = (is_branch & br_taken) | is_jal | is_jalr.
  - Target = EX_target_i.
- A bubble or an invalid EX slot writes a MEM slot with valid=0 and every EXMEM_* output at 0.
- mispredict_o = MEM.valid & ((is_jmp & (prediction ^ br_decision)) | (!is_jmp & br_decision)). JALR therefore always redirects.
- Squash = mispredict_o | flush_i. On squash, ID, EX and the next MEM are all written invalid, including the IF instruction presented that cycle.
- Priority: rst_i > squash > stall_i. When stall_i is set without squash: ID holds its value, EX <= bubble, MEM <= EX as normal.
- Counters:
  - branch_cnt increments when MEM.valid & is_jmp.
  - mispredict_cnt increments when mispredict_o.
  - Both saturate at all-ones.
  - cnt_clr_i overrides an increment in the same cycle (result 0).
- Reset: all slots invalid, every output 0, both counters 0.

## Timing
- IF metadata captured at edge N appears on EXMEM_* after edge N+2, i.e. 3 cycles after presentation, when there are no stalls. Each stall cycle adds 1.
- EX_* inputs are sampled at the same edge that moves EX into MEM; EXMEM_* is visible the following cycle.
- mispredict_o is combinational from the MEM registers and is high for exactly one cycle per mispredicting instruction.
- Counter values reflect an event one cycle after the event is visible on EXMEM_*.
- Reset asserted mid-flight discards all slots at that edge; no partial packet is emitted afterwards.

## Test plan
- Reset: hold rst_i 2 cycles with random inputs -> all outputs 0, counters 0.
- Correct taken branch: IF_pc=0x00000104, hit=1, pred=1, bias=1, ghr=0x5A; at EX is_branch=1, taken=1, target=0x80. Required response 3 cycles later: btb_wr_index=0x01, tag=0x000001, pht_wr_index=0x41, target=0x80, is_jmp=1, decision=1, pcplus4=0x108, mispredict_o=0; branch_cnt=1 the next cycle.
- Mispredict pred=0/taken=1 with two valid younger fetches behind it -> mispredict_o=1 for one cycle; the following 3 MEM cycles are bubbles (valid=0); mispredict_cnt=1.
- JALR, not predicted -> is_jmp=0, decision=1, mispredict_o=1; branch_cnt unchanged.
- stall_i high 2 cycles with a branch in ID -> the branch reaches MEM 2 cycles late with metadata intact; stall_i coinciding with a mispredict -> the squash wins and ID is invalid.
- CNT_WIDTH=4: 20 mispredicts -> mispredict_cnt stays 15; cnt_clr_i together with an event -> 0.
